// File: rtl/l2_port_scheduler_if.sv
// L2 port scheduler bundle: three L1-side requesters, the shared L2 port
// and the current-owner indication.
interface l2_port_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              p_read;
    logic [ADDR_W-1:0] p_address;
    logic [LINE_W-1:0] p_rdata;
    logic              p_resp;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    logic [1:0]        grant_id;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        input  p_read, p_address,
        output p_rdata, p_resp,
        output l2_read, l2_write, l2_address, l2_wdata,
        input  l2_rdata, l2_resp,
        output grant_id
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        output p_read, p_address,
        input  p_rdata, p_resp,
        input  l2_read, l2_write, l2_address, l2_wdata,
        output l2_rdata, l2_resp,
        input  grant_id
    );
endinterface

// File: rtl/l2_port_scheduler.sv
// Shares one L2 port among I-cache, D-cache and prefetcher.
// Priority D > I > P, with a starvation guard forcing I after D bursts.
module l2_port_scheduler #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    l2_port_scheduler_if.slave bus
);
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        BUSY_P = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WW-1:0]     i_wait_q, i_wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;

    logic d_req;
    logic i_starved;
    logic i_resp, d_resp, p_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_wait_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_wait_q <= i_wait_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_wait_d  = i_wait_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        p_resp    = 1'b0;
        d_req     = bus.d_read | bus.d_write;
        i_starved = (i_wait_q == LIMIT) && bus.i_read;

        unique case (state_q)
            IDLE: begin
                if (i_starved) begin
                    state_d  = BUSY_I;
                    addr_d   = bus.i_address;
                    wr_d     = 1'b0;
                    i_wait_d = '0;
                end else if (d_req) begin
                    state_d = BUSY_D;
                    addr_d  = bus.d_address;
                    wdata_d = bus.d_wdata;
                    wr_d    = bus.d_write;
                    // Count D wins that bypassed a waiting I, saturating
                    if (bus.i_read && i_wait_q != LIMIT)
                        i_wait_d = i_wait_q + WW'(1);
                end else if (bus.i_read) begin
                    state_d  = BUSY_I;
                    addr_d   = bus.i_address;
                    wr_d     = 1'b0;
                    i_wait_d = '0;
                end else if (bus.p_read) begin
                    state_d = BUSY_P;
                    addr_d  = bus.p_address;
                    wr_d    = 1'b0;
                end
            end
            BUSY_I: begin
                if (bus.l2_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.l2_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY_P: begin
                if (bus.l2_resp) begin
                    p_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.l2_read    = (state_q != IDLE) && !wr_q;
    assign bus.l2_write   = (state_q != IDLE) && wr_q;
    assign bus.l2_address = addr_q;
    assign bus.l2_wdata   = wdata_q;
    assign bus.grant_id   = state_q;

    assign bus.i_rdata = bus.l2_rdata;
    assign bus.d_rdata = bus.l2_rdata;
    assign bus.p_rdata = bus.l2_rdata;
    assign bus.i_resp  = i_resp;
    assign bus.d_resp  = d_resp;
    assign bus.p_resp  = p_resp;
endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed bench for l2_port_scheduler: grants, priority, starvation guard,
// reset mid-transaction and stray/one-cycle L2 responses.
module tb_l2_port_scheduler;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    l2_port_scheduler_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    l2_port_scheduler #(
        .ADDR_W(16),
        .LINE_W(128),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner gid answers now; owner drops its request unless keep is set.
    task automatic respond(input logic [1:0] gid,
                           input logic [127:0] rd,
                           input logic keep);
        check("pre_resp_gid", 128'(bus.grant_id), 128'(gid));
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = rd;
        #1;
        check("i_resp", 128'(bus.i_resp), 128'(gid == 2'd1));
        check("d_resp", 128'(bus.d_resp), 128'(gid == 2'd2));
        check("p_resp", 128'(bus.p_resp), 128'(gid == 2'd3));
        case (gid)
            2'd1: check("i_rdata", bus.i_rdata, rd);
            2'd2: check("d_rdata", bus.d_rdata, rd);
            default: check("p_rdata", bus.p_rdata, rd);
        endcase
        if (!keep) begin
            case (gid)
                2'd1: bus.i_read = 1'b0;
                2'd2: begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
                default: bus.p_read = 1'b0;
            endcase
        end
        tick();
        bus.l2_resp = 1'b0;
        #1;
        check("post_gid", 128'(bus.grant_id), 128'd0);
        check("post_rd", 128'(bus.l2_read | bus.l2_write), 128'd0);
        check("post_resp", 128'(bus.i_resp | bus.d_resp | bus.p_resp), 128'd0);
    endtask

    initial begin
        logic [127:0] a5;
        logic [127:0] wd;
        n_cmp = 0;
        n_bad = 0;
        a5 = {16{8'hA5}};
        wd = 128'h0123456789ABCDEF_FEDCBA9876543210;
        rst_n          = 1'b0;
        bus.i_read     = 1'b0;
        bus.i_address  = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_address  = '0;
        bus.d_wdata    = '0;
        bus.p_read     = 1'b0;
        bus.p_address  = '0;
        bus.l2_rdata   = '0;
        bus.l2_resp    = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_gid", 128'(bus.grant_id), 128'd0);
        check("rst_l2rw", 128'({bus.l2_read, bus.l2_write}), 128'd0);
        check("rst_addr", 128'(bus.l2_address), 128'd0);
        check("rst_wdata", bus.l2_wdata, 128'd0);
        check("rst_resp", 128'({bus.i_resp, bus.d_resp, bus.p_resp}), 128'd0);
        rst_n = 1'b1;

        // Single D read, L2 answers in the 4th BUSY cycle
        bus.d_read    = 1'b1;
        bus.d_address = 16'h1230;
        #1;
        check("d1_gid0", 128'(bus.grant_id), 128'd0);
        tick();
        check("d1_gid", 128'(bus.grant_id), 128'd2);
        check("d1_rd", 128'(bus.l2_read), 128'd1);
        check("d1_wr", 128'(bus.l2_write), 128'd0);
        check("d1_addr", 128'(bus.l2_address), 128'h1230);
        check("d1_noresp", 128'(bus.d_resp), 128'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("d1_hold_gid", 128'(bus.grant_id), 128'd2);
            check("d1_hold_resp", 128'(bus.d_resp), 128'd0);
        end
        respond(2'd2, a5, 1'b0);

        // D writeback, wdata/address change after grant
        bus.d_write   = 1'b1;
        bus.d_address = 16'h4440;
        bus.d_wdata   = wd;
        tick();
        check("wb_gid", 128'(bus.grant_id), 128'd2);
        check("wb_wr", 128'(bus.l2_write), 128'd1);
        check("wb_rd", 128'(bus.l2_read), 128'd0);
        check("wb_wdata", bus.l2_wdata, wd);
        bus.d_wdata   = {4{32'hDEADBEEF}};
        bus.d_address = 16'hFFFF;
        tick();
        tick();
        check("wb_wdata_held", bus.l2_wdata, wd);
        check("wb_addr_held", 128'(bus.l2_address), 128'h4440);
        check("wb_rd_held", 128'(bus.l2_read), 128'd0);
        respond(2'd2, 128'h5, 1'b0);

        // Simultaneous I, D, P: order D, I, P
        bus.i_read    = 1'b1;
        bus.i_address = 16'h1000;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h2000;
        bus.p_read    = 1'b1;
        bus.p_address = 16'h3000;
        tick();
        check("sim_d_addr", 128'(bus.l2_address), 128'h2000);
        check("sim_iwait1", 128'(dut.i_wait_q), 128'd1);
        respond(2'd2, 128'h11, 1'b0);
        tick();
        check("sim_i_gid", 128'(bus.grant_id), 128'd1);
        check("sim_i_addr", 128'(bus.l2_address), 128'h1000);
        check("sim_iwait0", 128'(dut.i_wait_q), 128'd0);
        respond(2'd1, 128'h22, 1'b0);
        tick();
        check("sim_p_gid", 128'(bus.grant_id), 128'd3);
        check("sim_p_addr", 128'(bus.l2_address), 128'h3000);
        check("sim_p_rd", 128'(bus.l2_read), 128'd1);
        respond(2'd3, 128'h33, 1'b0);

        // Starvation guard: 4 D grants, then I despite d_read
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("stv_d_gid", 128'(bus.grant_id), 128'd2);
            check("stv_iwait", 128'(dut.i_wait_q), 128'(n + 1));
            respond(2'd2, 128'(n), 1'b1);
        end
        tick();
        check("stv_i_gid", 128'(bus.grant_id), 128'd1);
        check("stv_iwait_clr", 128'(dut.i_wait_q), 128'd0);
        respond(2'd1, 128'h44, 1'b0);
        tick();
        check("stv_d_again", 128'(bus.grant_id), 128'd2);
        check("stv_iwait_hold", 128'(dut.i_wait_q), 128'd0);
        respond(2'd2, 128'h55, 1'b0);

        // Reset in BUSY_P, then a stray l2_resp
        bus.p_read    = 1'b1;
        bus.p_address = 16'h7770;
        tick();
        check("mr_gid", 128'(bus.grant_id), 128'd3);
        check("mr_rd", 128'(bus.l2_read), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mr_rd_drop", 128'(bus.l2_read), 128'd0);
        check("mr_gid0", 128'(bus.grant_id), 128'd0);
        check("mr_addr0", 128'(bus.l2_address), 128'd0);
        bus.p_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.l2_resp = 1'b1;
        #1;
        check("mr_stray_presp", 128'(bus.p_resp), 128'd0);
        tick();
        bus.l2_resp = 1'b0;
        check("mr_stray_gid", 128'(bus.grant_id), 128'd0);
        check("mr_stray_rd", 128'(bus.l2_read), 128'd0);

        // Stray l2_resp in IDLE, then one-cycle I hit
        bus.l2_resp = 1'b1;
        #1;
        check("sr_noresp",
              128'({bus.i_resp, bus.d_resp, bus.p_resp}), 128'd0);
        tick();
        check("sr_gid", 128'(bus.grant_id), 128'd0);
        bus.l2_resp   = 1'b0;
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0AB0;
        tick();
        check("oc_gid", 128'(bus.grant_id), 128'd1);
        check("oc_addr", 128'(bus.l2_address), 128'h0AB0);
        respond(2'd1, 128'h66, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/l2_port_scheduler.md
# l2_port_scheduler

Sequential scheduler that shares the single L2 cache port among three line-sized requesters: L1 instruction cache, L1 data cache, and the L1 instruction-stream prefetcher. Sits between the L1 caches and the L2 cache. It latches the winning request and drives the L2 port from registers until `l2_resp`. Priority is data > instruction > prefetch, with a starvation guard for the instruction side.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `LINE_W`, 128: cache line width.
- `STARVE_LIMIT`, 4: consecutive D grants tolerated while I waits before I is forced.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `i_read`  in  1: I-cache line read request.
- `i_address`  in  ADDR_W: I-cache line address.
- `i_rdata`  out  LINE_W: read line, equals `l2_rdata`.
- `i_resp`  out  1: I transaction complete.
- `d_read`, `d_write`  in  1 each: D-cache read / writeback request (never both high).
- `d_address`  in  ADDR_W: D-cache line address.
- `d_wdata`  in  LINE_W: D-cache writeback line.
- `d_rdata`  out  LINE_W: equals `l2_rdata`.
- `d_resp`  out  1: D transaction complete.
- `p_read`  in  1: prefetch line read request.
- `p_address`  in  ADDR_W: prefetch line address.
- `p_rdata`  out  LINE_W: equals `l2_rdata`.
- `p_resp`  out  1: prefetch complete.
- `l2_read`, `l2_write`  out  1 each: L2 request.
- `l2_address`  out  ADDR_W: registered granted address.
- `l2_wdata`  out  LINE_W: registered granted wdata.
- `l2_rdata`  in  LINE_W: L2 read line.
- `l2_resp`  in  1: L2 transaction complete.
- `grant_id`  out  2: current owner. 0 = none, 1 = I, 2 = D, 3 = P.

## Operation
- States: IDLE, BUSY_I, BUSY_D, BUSY_P.
- IDLE, evaluated each cycle in this order:
  - If `i_wait == STARVE_LIMIT` and `i_read`: go to BUSY_I.
  - Else if `d_read|d_write`: go to BUSY_D.
  - Else if `i_read`: go to BUSY_I.
  - Else if `p_read`: go to BUSY_P.
  - Else stay in IDLE.
- On the transition edge, latch the request into registers:
  - `l2_address` from the winner's address.
  - `l2_wdata` from `d_wdata` (D only; otherwise holds its previous value).
  - Op register: write = `d_write`; all other grants are reads.
- BUSY_x:
  - `l2_read` = latched op is read; `l2_write` = latched op is write.
  - Requester inputs are ignored; changing them has no effect on the L2 port.
  - On `l2_resp`=1: pulse the owner's `x_resp` in the same cycle (combinational), then return to IDLE on the next edge.
- `i_wait` counter (width clog2(STARVE_LIMIT+1)):
  - Increments on every IDLE→BUSY_D edge where `i_read`=1.
  - Clears on IDLE→BUSY_I.
  - Otherwise holds. Saturates at STARVE_LIMIT.
- Prefetch has no starvation guard; it is served only when I and D are both idle.
- `x_rdata` outputs are all wired to `l2_rdata`; only `x_resp` qualifies them.
- `grant_id` follows the state: IDLE = 0, BUSY_I = 1, BUSY_D = 2, BUSY_P = 3.

## Timing
- Reset (`rst_n`=0, asynchronous) values:
  - State IDLE, `i_wait`=0, `grant_id`=0.
  - `l2_read`=`l2_write`=0, all `x_resp`=0.
  - `l2_address`=0, `l2_wdata`=0.
- Reset mid-transaction: `l2_read`/`l2_write` drop immediately. A later stray `l2_resp` is ignored.
- Grant latency: a request seen in IDLE at cycle t drives `l2_read`/`l2_write` from cycle t+1.
- Completion: `x_resp` is high exactly in the cycle `l2_resp`=1 while in BUSY_x. The block is IDLE the following cycle.
- Minimum spacing between back-to-back L2 transactions: one IDLE cycle.
- Requester handshake: a requester holds its request until its `x_resp`, and drops it by the cycle after.
  - A request still high in the IDLE cycle after its resp is treated as a new request.
- `l2_resp` in IDLE is ignored: no `x_resp`, no state change.
- `l2_resp` in the first BUSY cycle is legal (single-cycle L2 hit) and completes the transaction.
- Simultaneous requests resolve strictly per the IDLE priority order.
- A request arriving in the same cycle as `l2_resp` waits for the following IDLE cycle.

## Test plan
- Reset and single D read:
  - Stimulus: release `rst_n`; `d_read`=1, `d_address`=16'h1230; L2 responds 3 cycles later with `l2_rdata`=128'hA5…A5.
  - Required: `l2_read`=1 with `l2_address`=16'h1230 from the next cycle; `d_resp` high exactly one cycle with `d_rdata`=A5…A5; `grant_id` sequence 0,2,2,2,2,0.
- D writeback:
  - Stimulus: `d_write`=1, `d_address`=16'h4440, `d_wdata`=128'h0123…; `d_wdata` changes to garbage after the grant.
  - Required: `l2_write`=1, `l2_wdata` stays 128'h0123… until `l2_resp`; `l2_read`=0 throughout.
- Simultaneous I, D, P:
  - Stimulus: `i_read`, `d_read`, `p_read` all asserted in the same IDLE cycle, held until each resp.
  - Required: service order D, I, P; one IDLE cycle between transactions; only the owner's `x_resp` pulses.
- Starvation guard:
  - Stimulus: `i_read` held continuously; `d_read` re-asserted immediately after each `d_resp`; STARVE_LIMIT=4.
  - Required: after 4 D grants, I is granted next even though `d_read`=1; then `i_wait` returns to 0.
- Reset mid-transaction:
  - Stimulus: in BUSY_P, pull `rst_n` low; release it; L2 then asserts a stray `l2_resp`.
  - Required: `l2_read` drops asynchronously; `p_resp` never asserts; `grant_id`=0; no state change on the stray `l2_resp`.
- Stray and one-cycle responses:
  - Stimulus: `l2_resp`=1 in IDLE; then `i_read` with `l2_resp` asserted in the first BUSY_I cycle.
  - Required: no `x_resp` for the IDLE pulse; `i_resp` asserts in cycle t+1; back in IDLE at t+2.
